reg_file_param: RTL and testbench

Parametrised multi-entry register file with one write port and two independently enabled, registered read ports. It includes write-to-read bypass, an optional hardwired-zero entry, and a sequential clear engine. It is the storage block for the datapath's operand registers. It generalises the single load-enabled 16-bit register to DEPTH entries of WIDTH bits with hold-when-not-enabled semantics on every output.

---
 rtl/reg_file_pkg.sv | 19 +
 rtl/reg_file_rd_port.sv | 40 ++++
 rtl/reg_file_param.sv | 74 +++++++
 tb/tb_reg_file_param.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types, defaults and helpers for the register file
// No ports; imported by reg_file_param and reg_file_rd_port.
package reg_file_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t CLEAR = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one registered read port with zero-entry check and write bypass
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   re, ra          read enable and address
//   busy            clear engine active; output holds while set
//   wr_acc, wa, wd  accepted write this cycle, its address and data (bypass source)
//   mem             full storage array
//   rd              registered read data, holds when not enabled
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         re,
    input  logic [AW-1:0]                ra,
    input  logic                         busy,
    input  logic                         wr_acc,
    input  logic [AW-1:0]                wa,
    input  logic [WIDTH-1:0]             wd,
    input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
    output logic [WIDTH-1:0]             rd
);

    logic [WIDTH-1:0] nxt;

    // Zero entry beats bypass, bypass beats the stored value.
    always_comb nxt = (ZERO_REG && ra == '0) ? '0 : (wr_acc && wa == ra) ? wd : mem[ra];

    always_ff @(posedge clk)
        if (reset)
            rd <= '0;
        else if (re && !busy)
            rd <= nxt;

endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: DEPTH x WIDTH register file, one write port, two registered read ports, sequential clear
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   we, wa, wd         write enable, address, data
//   clr                start sequential clear of every entry
//   re_a, ra_a, rd_a   read port A
//   re_b, ra_b, rd_b   read port B
//   busy               clear engine active
//   wr_drop            sticky: a write arrived while busy
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             clr,
    input  logic             re_a,
    input  logic [AW-1:0]    ra_a,
    output logic [WIDTH-1:0] rd_a,
    input  logic             re_b,
    input  logic [AW-1:0]    ra_b,
    output logic [WIDTH-1:0] rd_b,
    output logic             busy,
    output logic             wr_drop
);

    state_t                       state;
    logic [AW-1:0]                ptr;
    logic [DEPTH-1:0][WIDTH-1:0]  mem;
    logic                         wr_acc;

    assign busy   = (state == CLEAR);
    assign wr_acc = we && !busy && !clr && !(ZERO_REG && wa == '0);

    always_ff @(posedge clk)
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            mem     <= '0;
            wr_drop <= 1'b0;
        end else begin
            if (we && busy)
                wr_drop <= 1'b1;
            if (busy) begin
                mem[ptr] <= '0;
                // DEPTH is a power of two, so ptr wraps back to 0 on the last entry.
                ptr <= ptr + 1'b1;
                if (ptr == AW'(DEPTH - 1))
                    state <= IDLE;
            end else if (clr) begin
                state <= CLEAR;
                ptr   <= '0;
            end else if (wr_acc)
                mem[wa] <= wd;
        end

    reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_rd_a (
        .clk(clk), .reset(reset), .re(re_a), .ra(ra_a), .busy(busy),
        .wr_acc(wr_acc), .wa(wa), .wd(wd), .mem(mem), .rd(rd_a)
    );

    reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_rd_b (
        .clk(clk), .reset(reset), .re(re_b), .ra(ra_b), .busy(busy),
        .wr_acc(wr_acc), .wa(wa), .wd(wd), .mem(mem), .rd(rd_b)
    );

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: scoreboard bench for reg_file_param, plain and zero-entry variants side by side
module tb_reg_file_param;

    logic clk = 1'b0;
    logic reset = 1'b1, we = 1'b0, clr = 1'b0, re_a = 1'b0, re_b = 1'b0;
    logic [2:0] wa = '0, ra_a = '0, ra_b = '0;
    logic [15:0] wd = '0;
    logic [15:0] rd_a0, rd_b0, rd_a1, rd_b1;
    logic busy0, busy1, drop0, drop1;

    always #5 clk = ~clk;

    reg_file_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b0)) dut (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .clr(clr),
        .re_a(re_a), .ra_a(ra_a), .rd_a(rd_a0), .re_b(re_b), .ra_b(ra_b), .rd_b(rd_b0),
        .busy(busy0), .wr_drop(drop0)
    );

    reg_file_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b1)) dz (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .clr(clr),
        .re_a(re_a), .ra_a(ra_a), .rd_a(rd_a1), .re_b(re_b), .ra_b(ra_b), .rd_b(rd_b1),
        .busy(busy1), .wr_drop(drop1)
    );

    typedef struct packed {
        logic [15:0] a0, b0, a1, b1;
        logic        busy, drop;
    } exp_t;

    exp_t q[$];
    int checks = 0, passed = 0;

    // Reference: index 0 is the plain file, index 1 has the hardwired zero entry.
    // A clear is modelled as "contents vanish, ports frozen for 8 cycles".
    logic [15:0] mem [2][8];
    logic [15:0] rda [2], rdb [2];
    int left = 0;
    bit drop = 0;

    task automatic model();
        bit b, acc;
        b = left > 0;
        if (reset) begin
            left = 0;
            drop = 0;
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 8; i++) mem[d][i] = '0;
                rda[d] = '0;
                rdb[d] = '0;
            end
            return;
        end
        if (we && b) drop = 1;
        for (int d = 0; d < 2; d++) begin
            acc = we && !b && !clr && !(d == 1 && wa == 0);
            if (re_a && !b) rda[d] = (d == 1 && ra_a == 0) ? 16'h0 : (acc && wa == ra_a) ? wd : mem[d][ra_a];
            if (re_b && !b) rdb[d] = (d == 1 && ra_b == 0) ? 16'h0 : (acc && wa == ra_b) ? wd : mem[d][ra_b];
            if (acc) mem[d][wa] = wd;
        end
        if (b) left--;
        else if (clr) begin
            left = 8;
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 8; i++) mem[d][i] = '0;
        end
    endtask

    task automatic drive(input bit r, input bit w, input int a, input int d, input bit c,
                         input bit ea, input int xa, input bit eb, input int xb);
        exp_t e;
        reset = r; we = w; wa = 3'(a); wd = 16'(d); clr = c;
        re_a = ea; ra_a = 3'(xa); re_b = eb; ra_b = 3'(xb);
        model();
        e = '{a0: rda[0], b0: rdb[0], a1: rda[1], b1: rdb[1], busy: left > 0, drop: drop};
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 1, i, 1, 7 - i);
    endtask

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    endtask

    always @(negedge clk)
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rd_a", rd_a0, e.a0);
            chk("rd_b", rd_b0, e.b0);
            chk("rd_a_zr", rd_a1, e.a1);
            chk("rd_b_zr", rd_b1, e.b1);
            chk("busy", 16'(busy0), 16'(e.busy));
            chk("busy_zr", 16'(busy1), 16'(e.busy));
            chk("wr_drop", 16'(drop0), 16'(e.drop));
            chk("wr_drop_zr", 16'(drop1), 16'(e.drop));
        end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        read_all();
        drive(0, 1, 3, 16'hBEEF, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 3, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 5, 0, 0);
        drive(0, 1, 6, 16'h1234, 0, 0, 0, 1, 6);
        drive(0, 1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0);
        drive(0, 1, 1, 16'h5A5A, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 1, 1);
        drive(0, 1, 2, 16'h7777, 1, 1, 2, 1, 2);
        for (int i = 0; i < 8; i++) drive(0, 1, i, 16'h1000 + i, 0, 0, 0, 0, 0);
        read_all();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
        drive(0, 1, 4, 16'hDEAD, 0, 1, 4, 1, 4);
        idle(8);
        read_all();
        for (int i = 0; i < 8; i++) drive(0, 1, i, 16'h2000 + i, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(2);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 3, 1, 5);
        idle(9);
        read_all();
        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                  $urandom, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7));
        idle(2);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: %0d expected entries left, required 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
